i2c_target_rx: RTL and testbench

- Serial-in/parallel-out I2C target receiver. It is the deserialising counterpart of the parallel-load shift unit that feeds the controller's transmit path.
- It oversamples SCL/SDA on the system clock and detects START/STOP. It then shifts in an address byte and data bytes MSB-first.
- It drives the ACK/NACK bit on SDA and presents each received data byte as a one-cycle valid strobe to the memory subsystem.

---
 rtl/i2c_pkg.sv | 17 +
 rtl/i2c_bus_sync.sv | 47 ++++
 rtl/i2c_target_rx.sv | 167 ++++++++++++++++
 tb/tb_i2c_target_rx.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared state encoding and byte/R-W constants for the I2C target receiver
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        DATA,
        DATA_ACK,
        IGNORE
    } rx_state_t;

    localparam int   I2C_BYTE_W = 8;
    localparam logic I2C_WRITE  = 1'b0;
    localparam logic I2C_READ   = 1'b1;

endpackage

// File: rtl/i2c_bus_sync.sv
// rtl/i2c_bus_sync.sv - SCL/SDA synchroniser with SCL edge and START/STOP detection
module i2c_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic scl_pin,
    input  logic sda_pin,
    output logic sda_level,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    logic [SYNC_STAGES-1:0] scl_ff;
    logic [SYNC_STAGES-1:0] sda_ff;
    logic                   scl_hist;
    logic                   sda_hist;
    logic                   scl_s;
    logic                   sda_s;

    // Preset high so leaving reset on an idle bus never looks like an edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scl_ff   <= '1;
            sda_ff   <= '1;
            scl_hist <= 1'b1;
            sda_hist <= 1'b1;
        end else begin
            scl_ff   <= {scl_ff[SYNC_STAGES-2:0], scl_pin};
            sda_ff   <= {sda_ff[SYNC_STAGES-2:0], sda_pin};
            scl_hist <= scl_ff[SYNC_STAGES-1];
            sda_hist <= sda_ff[SYNC_STAGES-1];
        end
    end

    assign scl_s     = scl_ff[SYNC_STAGES-1];
    assign sda_s     = sda_ff[SYNC_STAGES-1];
    assign sda_level = sda_s;
    assign scl_rise  = scl_s & ~scl_hist;
    assign scl_fall  = ~scl_s & scl_hist;
    // SCL must be high on both samples so an SCL edge is never read as START/STOP.
    assign start_det = scl_s & scl_hist & sda_hist & ~sda_s;
    assign stop_det  = scl_s & scl_hist & ~sda_hist & sda_s;

endmodule

// File: rtl/i2c_target_rx.sv
// rtl/i2c_target_rx.sv - I2C write-only target: address match, byte deserialiser and ACK driver
module i2c_target_rx
    import i2c_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR    = 7'h50,
    parameter int         SYNC_STAGES = 2,
    parameter int         N           = I2C_BYTE_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         scl_i,
    input  logic         sda_i,
    output logic         sda_oe,
    input  logic         ack_en,
    output logic [N-1:0] rx_data,
    output logic         rx_valid,
    output logic         rx_first,
    output logic         busy,
    output logic         addr_match
);

    localparam int CW = $clog2(N);

    rx_state_t      state, state_n;
    logic [CW-1:0]  bit_cnt, bit_cnt_n;
    logic [N-1:0]   shreg, shreg_n, byte_in;
    logic           full, full_n;
    logic           first_pend, first_pend_n;
    logic           ack_lat, ack_lat_n;
    logic           sda_oe_n, busy_n, addr_match_n;
    logic [N-1:0]   rx_data_n;
    logic           rx_valid_n, rx_first_n;
    logic           last_bit;

    logic sda_s, scl_rise, scl_fall, start_det, stop_det;

    i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk       (clk),
        .rst       (rst),
        .scl_pin   (scl_i),
        .sda_pin   (sda_i),
        .sda_level (sda_s),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    assign byte_in  = {shreg[N-2:0], sda_s};
    assign last_bit = (bit_cnt == CW'(N - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            shreg      <= '0;
            full       <= 1'b0;
            first_pend <= 1'b0;
            ack_lat    <= 1'b0;
            sda_oe     <= 1'b0;
            busy       <= 1'b0;
            addr_match <= 1'b0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            rx_first   <= 1'b0;
        end else begin
            state      <= state_n;
            bit_cnt    <= bit_cnt_n;
            shreg      <= shreg_n;
            full       <= full_n;
            first_pend <= first_pend_n;
            ack_lat    <= ack_lat_n;
            sda_oe     <= sda_oe_n;
            busy       <= busy_n;
            addr_match <= addr_match_n;
            rx_data    <= rx_data_n;
            rx_valid   <= rx_valid_n;
            rx_first   <= rx_first_n;
        end
    end

    always_comb begin
        state_n      = state;
        bit_cnt_n    = bit_cnt;
        shreg_n      = shreg;
        full_n       = full;
        first_pend_n = first_pend;
        ack_lat_n    = ack_lat;
        sda_oe_n     = sda_oe;
        busy_n       = busy;
        addr_match_n = addr_match;
        rx_data_n    = rx_data;
        rx_valid_n   = 1'b0;
        rx_first_n   = 1'b0;

        if (start_det) begin
            state_n      = ADDR;
            bit_cnt_n    = '0;
            full_n       = 1'b0;
            sda_oe_n     = 1'b0;
            addr_match_n = 1'b0;
            busy_n       = 1'b1;
        end else if (stop_det) begin
            state_n      = IDLE;
            bit_cnt_n    = '0;
            full_n       = 1'b0;
            sda_oe_n     = 1'b0;
            addr_match_n = 1'b0;
            busy_n       = 1'b0;
        end else begin
            case (state)
                IDLE: ;
                ADDR: begin
                    if (scl_rise && !full) begin
                        shreg_n   = byte_in;
                        full_n    = last_bit;
                        bit_cnt_n = last_bit ? '0 : bit_cnt + 1'b1;
                    end else if (scl_fall && full) begin
                        full_n = 1'b0;
                        if (shreg[N-1:1] == DEV_ADDR && shreg[0] != I2C_READ) begin
                            sda_oe_n = 1'b1;
                            state_n  = ADDR_ACK;
                        end else begin
                            state_n  = IGNORE;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        sda_oe_n     = 1'b0;
                        addr_match_n = 1'b1;
                        first_pend_n = 1'b1;
                        state_n      = DATA;
                    end
                end
                DATA: begin
                    if (scl_rise && !full) begin
                        shreg_n   = byte_in;
                        full_n    = last_bit;
                        bit_cnt_n = last_bit ? '0 : bit_cnt + 1'b1;
                        if (last_bit) begin
                            rx_data_n    = byte_in;
                            rx_valid_n   = 1'b1;
                            rx_first_n   = first_pend;
                            first_pend_n = 1'b0;
                            ack_lat_n    = ack_en;
                        end
                    end else if (scl_fall && full) begin
                        full_n   = 1'b0;
                        sda_oe_n = ack_lat;
                        state_n  = DATA_ACK;
                    end
                end
                DATA_ACK: begin
                    if (scl_fall) begin
                        sda_oe_n  = 1'b0;
                        bit_cnt_n = '0;
                        state_n   = ack_lat ? DATA : IGNORE;
                    end
                end
                IGNORE:  sda_oe_n = 1'b0;
                default: state_n  = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_target_rx.sv
// tb/tb_i2c_target_rx.sv - randomized self-checking bench for i2c_target_rx against a transaction-level model
module tb_i2c_target_rx;

    logic       clk = 1'b0;
    logic       rst;
    logic       scl_m, sda_m, ack_en;
    logic       scl_i, sda_i;
    logic       sda_oe, rx_valid, rx_first, busy, addr_match;
    logic [7:0] rx_data;

    int errors = 0;
    int checks = 0;

    logic [8:0] rxq[$];
    logic [8:0] expq[$];
    logic [7:0] tx_bytes[$];
    bit         tx_acks[$];

    assign scl_i = scl_m;
    assign sda_i = sda_m & ~sda_oe;

    always #5 clk = ~clk;

    i2c_target_rx #(.DEV_ADDR(7'h50), .SYNC_STAGES(2), .N(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .scl_i      (scl_i),
        .sda_i      (sda_i),
        .sda_oe     (sda_oe),
        .ack_en     (ack_en),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_first   (rx_first),
        .busy       (busy),
        .addr_match (addr_match)
    );

    always @(negedge clk)
        if (rst === 1'b1 && rx_valid === 1'b1) rxq.push_back({rx_first, rx_data});

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic ticks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input bit b);
        ticks(5); sda_m = b;
        ticks(5); scl_m = 1'b1;
        ticks(8); scl_m = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, output bit acked);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        ticks(5); sda_m = 1'b1;
        ticks(5); scl_m = 1'b1;
        ticks(4); acked = sda_oe;
        ticks(4); scl_m = 1'b0;
    endtask

    task automatic bus_start();
        ticks(5); sda_m = 1'b1;
        ticks(5); scl_m = 1'b1;
        ticks(5); sda_m = 1'b0;
        ticks(5); scl_m = 1'b0;
    endtask

    task automatic bus_stop();
        ticks(5); sda_m = 1'b0;
        ticks(5); scl_m = 1'b1;
        ticks(5); sda_m = 1'b1;
        ticks(10);
    endtask

    // Model: a write to 0x50 is ACKed; each data byte while still accepted yields one strobe
    // (first flagged on byte 0) and is ACKed iff ack_en; the first NACK ends reception.
    task automatic run_txn(input logic [7:0] addr, input bit clear, input string name);
        bit got, exp_ack, alive;
        expq.delete();
        if (clear) rxq.delete();
        bus_start();
        check({name, ".busy"}, busy, 1);
        exp_ack = (addr[7:1] == 7'h50) && (addr[0] == 1'b0);
        send_byte(addr, got);
        check({name, ".addr_ack"}, got, exp_ack);
        alive = exp_ack;
        foreach (tx_bytes[i]) begin
            ack_en = tx_acks[i];
            send_byte(tx_bytes[i], got);
            check($sformatf("%s.ack%0d", name, i), got, alive && tx_acks[i]);
            if (alive) expq.push_back({(i == 0), tx_bytes[i]});
            alive = alive && tx_acks[i];
        end
        check({name, ".addr_match"}, addr_match, exp_ack);
        bus_stop();
        check({name, ".busy_end"}, busy, 0);
        check({name, ".sda_oe_end"}, sda_oe, 0);
        check({name, ".nstrobe"}, rxq.size(), expq.size());
        for (int i = 0; i < expq.size() && i < rxq.size(); i++)
            check($sformatf("%s.strobe%0d", name, i), rxq[i], expq[i]);
    endtask

    initial begin
        #20_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        bit         got;
        logic [7:0] addr;
        int         n;

        rst = 1'b0; scl_m = 1'b1; sda_m = 1'b1; ack_en = 1'b1;
        ticks(3);
        check("rst.sda_oe", sda_oe, 0);
        check("rst.rx_valid", rx_valid, 0);
        check("rst.rx_first", rx_first, 0);
        check("rst.busy", busy, 0);
        check("rst.addr_match", addr_match, 0);
        check("rst.rx_data", rx_data, 0);
        rst = 1'b1;
        ticks(5);

        tx_bytes = '{8'h3C};                  tx_acks = '{1};       run_txn(8'hA0, 1, "single");
        tx_bytes = '{8'h11};                  tx_acks = '{1};       run_txn(8'h52, 1, "wrong_addr");
        tx_bytes = '{8'h44};                  tx_acks = '{1};       run_txn(8'hA1, 1, "read_addr");
        tx_bytes = '{8'h01, 8'h02, 8'h03};    tx_acks = '{1, 1, 1}; run_txn(8'hA0, 1, "three");
        tx_bytes = '{8'h55, 8'h66};           tx_acks = '{0, 1};    run_txn(8'hA0, 1, "nack");

        rxq.delete();
        ack_en = 1'b1;
        bus_start();
        send_byte(8'hA0, got);
        check("rs.first_addr_ack", got, 1);
        for (int i = 0; i < 4; i++) send_bit(1'($urandom_range(0, 1)));
        tx_bytes = '{8'h77}; tx_acks = '{1};
        run_txn(8'hA0, 0, "rs");

        ack_en = 1'b1;
        bus_start();
        send_byte(8'hA0, got);
        for (int i = 7; i >= 0; i--) send_bit(1'(i % 2));
        ticks(5); sda_m = 1'b1;
        ticks(5); scl_m = 1'b1;
        ticks(4);
        check("mid.sda_oe", sda_oe, 1);
        rst = 1'b0;
        #1;
        check("arst.sda_oe", sda_oe, 0);
        check("arst.rx_valid", rx_valid, 0);
        check("arst.rx_first", rx_first, 0);
        check("arst.busy", busy, 0);
        check("arst.addr_match", addr_match, 0);
        check("arst.rx_data", rx_data, 0);
        ticks(2);
        scl_m = 1'b1; sda_m = 1'b1;
        ticks(5);
        rst = 1'b1;
        ticks(5);
        check("arst.idle_busy", busy, 0);
        tx_bytes = '{8'h9E}; tx_acks = '{1}; run_txn(8'hA0, 1, "post_rst");

        for (int t = 0; t < 20; t++) begin
            addr = ($urandom_range(0, 1) != 0) ? 8'hA0 : 8'($urandom);
            n = $urandom_range(1, 4);
            tx_bytes.delete(); tx_acks.delete();
            for (int i = 0; i < n; i++) begin
                tx_bytes.push_back(8'($urandom));
                tx_acks.push_back($urandom_range(0, 3) != 0);
            end
            run_txn(addr, 1, $sformatf("rnd%0d", t));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
